mem_access_unit: RTL and testbench

- Initiator-side load/store unit for the RV32I core; it is the master that drives the zeroDelayRAM port (RAMAddr, DataIn, RAMWriteControl) and consumes RAMOut.
- Accepts one byte, halfword or word load or store from the execute stage over a valid/ready request, then returns a single-cycle response.
- Performs sign or zero extension on loads.
- Performs read-modify-write for sub-word stores, because the RAM writes whole words only.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/load_extend.sv | 30 +++
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, funct3 width codes and legality/alignment checks.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    case (f3)
      F3_H, F3_HU: return !a[0];
      F3_W:        return a == 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  // Stores have no unsigned variants.
  function automatic logic is_legal(
    input logic       wr,
    input logic [2:0] f3
  );
    if (wr)
      return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension.
// Ports: word (RAM word), addr (byte offset), funct3 (width code) -> result.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word[{addr, 3'b000} +: 8];
  assign w_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   result = {24'd0, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_HU:   result = {16'd0, w_half};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit mastering a word-wide zero-delay RAM.
// Ports: valid/ready request, one-cycle response, RAM addr/data/write/readback.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [RAMAddrSize-1:0] req_addr,
  input  logic [dataW-1:0]       req_wdata,
  output logic                   resp_valid,
  output logic [dataW-1:0]       resp_rdata,
  output logic                   resp_err,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       DataIn,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMOut
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_write;
  logic [2:0]             r_f3;
  logic [RAMAddrSize-1:0] r_addr;
  logic [dataW-1:0]       r_wdata;
  logic [dataW-1:0]       r_merge;
  logic [dataW-1:0]       r_rdata;
  logic                   r_err;
  logic                   w_err;
  logic [31:0]            w_ext;
  logic [dataW-1:0]       w_merge;

  assign w_err = !is_legal(req_write, req_funct3)
              || !is_aligned(req_funct3, req_addr[1:0]);

  load_extend u_ext (
    .word   (RAMOut),
    .addr   (r_addr[1:0]),
    .funct3 (r_f3),
    .result (w_ext)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_write <= req_write;
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_rdata <= '0;
          r_err   <= w_err;
        end
        LOAD:     r_rdata <= w_ext;
        RMW_READ: r_merge <= RAMOut;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) begin
        if (w_err)
          w_next = RESP;
        else if (!req_write)
          w_next = LOAD;
        else if (req_funct3 == F3_W)
          w_next = WRITE;
        else
          w_next = RMW_READ;
      end
      LOAD:     w_next = RESP;
      RMW_READ: w_next = WRITE;
      WRITE:    w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Only the addressed lane of the read-back word is replaced.
  always_comb begin
    w_merge = r_merge;
    case (r_f3)
      F3_B: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      F3_H: w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  assign req_ready       = r_state == IDLE;
  assign resp_valid      = r_state == RESP;
  assign resp_err        = resp_valid && r_err;
  assign resp_rdata      = (resp_valid && !r_write) ? r_rdata : '0;
  assign RAMWriteControl = r_state == WRITE;
  assign DataIn          = RAMWriteControl ? w_merge : '0;
  assign RAMAddr         = {r_addr[RAMAddrSize-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural zero-delay RAM.
// Checks reset, latency, extension, merge, errors, handshake and reset abort.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  RAMAddr;
  logic [31:0] DataIn;
  logic        RAMWriteControl;
  logic [31:0] RAMOut;

  logic [31:0] mem [64] = '{default: 32'd0};

  int n_asserts = 0;
  int n_fails   = 0;

  int          g_lat;
  int          g_wcnt;
  int          g_wcyc;
  logic [31:0] g_rd;
  logic        g_er;

  always #5 clock = ~clock;

  assign RAMOut = mem[RAMAddr[7:2]];

  always @(posedge clock)
    if (RAMWriteControl)
      mem[RAMAddr[7:2]] <= DataIn;

  mem_access_unit #(.dataW(32), .RAMAddrSize(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .RAMAddr         (RAMAddr),
    .DataIn          (DataIn),
    .RAMWriteControl (RAMWriteControl),
    .RAMOut          (RAMOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch up to 8 cycles for its response.
  task automatic run(input logic w, input logic [2:0] f3,
                     input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    g_lat = 0; g_wcnt = 0; g_wcyc = 0; g_rd = '0; g_er = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i == 1) begin
        req_valid = 1'b0;
        req_addr  = 8'hFF;
        req_wdata = 32'h5A5A_5A5A;
      end
      if (RAMWriteControl) begin
        g_wcnt++;
        g_wcyc = i;
      end
      if (resp_valid) begin
        g_lat = i;
        g_rd  = resp_rdata;
        g_er  = resp_err;
        break;
      end
    end
  endtask

  task automatic expect_resp(input string tag, input int lat,
                             input logic [31:0] rd, input logic er,
                             input int wcnt);
    chk({tag, "_lat"},  g_lat, lat);
    chk({tag, "_rd"},   g_rd, rd);
    chk({tag, "_err"},  {31'd0, g_er}, {31'd0, er});
    chk({tag, "_wcnt"}, g_wcnt, wcnt);
  endtask

  logic seen;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    #3;
    chk("rst_we",    {31'd0, RAMWriteControl}, 32'd0);
    chk("rst_addr",  {24'd0, RAMAddr}, 32'd0);
    chk("rst_din",   DataIn, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err",   {31'd0, resp_err}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rst_ready", {31'd0, req_ready}, 32'd1);

    run(1'b1, F3_W, 8'd64, 32'h1234_5678);
    expect_resp("sw64", 2, 32'd0, 1'b0, 1);
    chk("sw64_mem", mem[16], 32'h1234_5678);

    run(1'b0, F3_W, 8'd64, 32'd0);
    expect_resp("lw64", 2, 32'h1234_5678, 1'b0, 0);

    run(1'b1, F3_W, 8'd68, 32'hAABB_CCDD);
    expect_resp("sw68", 2, 32'd0, 1'b0, 1);
    run(1'b1, F3_B, 8'd69, 32'hFFFF_FF11);
    expect_resp("sb69", 3, 32'd0, 1'b0, 1);
    chk("sb69_wcyc", g_wcyc, 2);
    chk("sb69_mem", mem[17], 32'hAABB_11DD);
    run(1'b1, F3_H, 8'd70, 32'hFFFF_5566);
    expect_resp("sh70", 3, 32'd0, 1'b0, 1);
    chk("sh70_mem", mem[17], 32'h5566_11DD);

    run(1'b1, F3_W, 8'd72, 32'h0000_80F0);
    expect_resp("sw72", 2, 32'd0, 1'b0, 1);
    run(1'b0, F3_B, 8'd72, 32'd0);
    expect_resp("lb72", 2, 32'hFFFF_FFF0, 1'b0, 0);
    run(1'b0, F3_BU, 8'd72, 32'd0);
    expect_resp("lbu72", 2, 32'h0000_00F0, 1'b0, 0);
    run(1'b0, F3_H, 8'd72, 32'd0);
    expect_resp("lh72", 2, 32'hFFFF_80F0, 1'b0, 0);
    run(1'b0, F3_HU, 8'd72, 32'd0);
    expect_resp("lhu72", 2, 32'h0000_80F0, 1'b0, 0);
    run(1'b0, F3_B, 8'd73, 32'd0);
    expect_resp("lb73", 2, 32'hFFFF_FF80, 1'b0, 0);
    run(1'b0, F3_HU, 8'd70, 32'd0);
    expect_resp("lhu70", 2, 32'h0000_5566, 1'b0, 0);

    run(1'b0, F3_W, 8'd66, 32'd0);
    expect_resp("lw66", 1, 32'd0, 1'b1, 0);
    chk("lw66_mem", mem[16], 32'h1234_5678);
    run(1'b1, F3_H, 8'd65, 32'h0000_FFFF);
    expect_resp("sh65", 1, 32'd0, 1'b1, 0);
    chk("sh65_mem", mem[16], 32'h1234_5678);
    run(1'b0, 3'b011, 8'd64, 32'd0);
    expect_resp("f3_011", 1, 32'd0, 1'b1, 0);
    chk("f3_011_mem", mem[16], 32'h1234_5678);
    run(1'b1, F3_BU, 8'd64, 32'hFFFF_FFFF);
    expect_resp("sbu", 1, 32'd0, 1'b1, 0);
    chk("sbu_mem", mem[16], 32'h1234_5678);

    run(1'b1, F3_W, 8'd64, 32'd55);
    expect_resp("pre55", 2, 32'd0, 1'b0, 1);
    run(1'b1, F3_W, 8'd68, 32'd91);
    expect_resp("pre91", 2, 32'd0, 1'b0, 1);

    // Requester keeps valid high across both loads.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0;
    req_funct3 = F3_W; req_addr = 8'd64;
    @(negedge clock);
    chk("b2b_busy1", {31'd0, req_ready}, 32'd0);
    chk("b2b_addr_lo", {30'd0, RAMAddr[1:0]}, 32'd0);
    req_addr = 8'd68;
    @(negedge clock);
    chk("b2b_v1", {31'd0, resp_valid}, 32'd1);
    chk("b2b_r1", resp_rdata, 32'd55);
    chk("b2b_busy2", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);
    chk("b2b_gap", {31'd0, resp_valid}, 32'd0);
    @(negedge clock);
    chk("b2b_busy3", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    chk("b2b_v2", {31'd0, resp_valid}, 32'd1);
    chk("b2b_r2", resp_rdata, 32'd91);

    run(1'b1, F3_W, 8'd8, 32'h1111_1111);
    expect_resp("pre8", 2, 32'd0, 1'b0, 1);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1;
    req_funct3 = F3_W; req_addr = 8'd8; req_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort_we_on", {31'd0, RAMWriteControl}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_we_off", {31'd0, RAMWriteControl}, 32'd0);
    chk("abort_din", DataIn, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_mem", mem[2], 32'h1111_1111);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_noresp", {31'd0, seen}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem2", mem[2], 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
